// File: rtl/tmon_master_if.sv
// ---------------------------------------------------------------------------
// tmon_master_if : host command/response and tmon bus signals for tmon_master
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tmon_master_if #(
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_opnd;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic [3:0]    bus_op;
  logic [DW-1:0] bus_opnd;
  logic          bus_ready;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic [1:0]    bus_status;

  logic [1:0]    alarm;
  logic          alarm_chg;

  modport master (
    input  req_valid, req_op, req_opnd, rsp_ready,
           bus_ready, bus_valid, bus_data, bus_status,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           bus_op, bus_opnd, alarm, alarm_chg
  );

  modport slave (
    output req_valid, req_op, req_opnd, rsp_ready,
           bus_ready, bus_valid, bus_data, bus_status,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           bus_op, bus_opnd, alarm, alarm_chg
  );
endinterface

`default_nettype wire

// File: rtl/tmon_master.sv
// ---------------------------------------------------------------------------
// tmon_master : host-command to tmon-bus sequencer with timeout and alarm mirror
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmon_master #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  tmon_master_if.master   tm
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RDY  = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [3:0] OP_NOOP = 4'b1000;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [3:0]    bus_op_q, bus_op_d;
  logic [DW-1:0] bus_opnd_q, bus_opnd_d;
  logic [1:0]    alarm_q, alarm_d;
  logic [1:0]    alarm_prev_q, alarm_prev_d;
  logic          alarm_chg_q, alarm_chg_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOOP;
      opnd_q       <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      bus_op_q     <= OP_NOOP;
      bus_opnd_q   <= '0;
      alarm_q      <= 2'd0;
      alarm_prev_q <= 2'd0;
      alarm_chg_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      bus_op_q     <= bus_op_d;
      bus_opnd_q   <= bus_opnd_d;
      alarm_q      <= alarm_d;
      alarm_prev_q <= alarm_prev_d;
      alarm_chg_q  <= alarm_chg_d;
    end
  end

  // Awaited input is checked before the timeout so it wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tm.req_valid) state_d = tm.req_op[3] ? S_RESP : S_WAIT_RDY;
      S_WAIT_RDY:  if (tm.bus_ready) state_d = S_ISSUE;
                   else if (cnt_q == CNT_LAST) state_d = S_RESP;
      S_ISSUE:     state_d = op_q[2] ? S_WAIT_DATA : S_RESP;
      S_WAIT_DATA: if (tm.bus_valid || cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP:      if (tm.rsp_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    // bus_op is NOOP everywhere except the single ISSUE cycle.
    bus_op_d   = (state_d == S_ISSUE) ? op_q : OP_NOOP;
    bus_opnd_d = (state_d == S_ISSUE) ? opnd_q : bus_opnd_q;

    alarm_d      = tm.bus_status;
    alarm_prev_d = alarm_q;
    alarm_chg_d  = (alarm_q != alarm_prev_q);

    case (state_q)
      S_IDLE: begin
        if (tm.req_valid) begin
          op_d       = tm.req_op;
          opnd_d     = tm.req_opnd;
          cnt_d      = 8'd0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        cnt_d = cnt_q + 8'd1;
        if (state_d == S_RESP) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d      = 8'd0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
      end
      S_WAIT_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (tm.bus_valid) begin
          rsp_data_d = tm.bus_data;
          rsp_err_d  = 1'b0;
        end else if (state_d == S_RESP) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tm.req_ready = (state_q == S_IDLE);
    tm.rsp_valid = (state_q == S_RESP);
    tm.rsp_data  = rsp_data_q;
    tm.rsp_err   = rsp_err_q;
    tm.bus_op    = bus_op_q;
    tm.bus_opnd  = bus_opnd_q;
    tm.alarm     = alarm_q;
    tm.alarm_chg = alarm_chg_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_tmon_master.sv
// ---------------------------------------------------------------------------
// tb_tmon_master : directed vector table plus hand sequences for tmon_master
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tmon_master;

  localparam int NEVER = 1000;

  typedef struct {
    logic [3:0] op;
    logic [7:0] opnd;
    int         rdy_at;
    int         vld_dly;
    logic [7:0] bdata;
    int         exp_lat;
    int         exp_issues;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] last_opnd;
  vec_t vecs [13];

  tmon_master_if #(.DW(8)) tmif ();

  tmon_master #(.DW(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .tm    (tmif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, issues, issue_at;
    bit done;
    logic [3:0] seen_op;
    logic [7:0] seen_opnd;
    lat = 0; issues = 0; issue_at = 0; done = 0;
    seen_op = 4'b1000; seen_opnd = 8'h00;
    @(negedge clk);
    tmif.bus_ready = (v.rdy_at == 0);
    tmif.req_valid = 1'b1;
    tmif.req_op    = v.op;
    tmif.req_opnd  = v.opnd;
    check($sformatf("v%0d req_ready", idx), 32'(tmif.req_ready), 32'd1);
    @(negedge clk);
    tmif.req_valid = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (n > 1) @(negedge clk);
      if (tmif.rsp_valid) begin
        lat  = n;
        done = 1;
      end else begin
        if (tmif.bus_op !== 4'b1000) begin
          issues++;
          issue_at  = n;
          seen_op   = tmif.bus_op;
          seen_opnd = tmif.bus_opnd;
        end
        tmif.bus_ready = (v.rdy_at != NEVER) && (n >= v.rdy_at);
        tmif.bus_valid = (issue_at != 0) && (n == issue_at + v.vld_dly);
        tmif.bus_data  = tmif.bus_valid ? v.bdata : 8'h00;
      end
    end
    tmif.bus_valid = 1'b0;
    tmif.bus_data  = 8'h00;
    if (v.exp_issues != 0) last_opnd = v.opnd;
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d issue_cycles", idx), 32'(issues), 32'(v.exp_issues));
    check($sformatf("v%0d bus_op", idx), 32'(seen_op), (v.exp_issues != 0) ? 32'(v.op) : 32'h8);
    check($sformatf("v%0d bus_opnd_issue", idx), 32'(seen_opnd), (v.exp_issues != 0) ? 32'(v.opnd) : 32'h0);
    check($sformatf("v%0d rsp_data", idx), 32'(tmif.rsp_data), 32'(v.exp_data));
    check($sformatf("v%0d rsp_err", idx), 32'(tmif.rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d bus_opnd_hold", idx), 32'(tmif.bus_opnd), 32'(last_opnd));
    tmif.rsp_ready = 1'b1;
    @(negedge clk);
    tmif.rsp_ready = 1'b0;
    check($sformatf("v%0d rsp_valid_drop", idx), 32'(tmif.rsp_valid), 32'd0);
    check($sformatf("v%0d back_idle", idx), 32'(tmif.req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] st [9];
    logic [1:0] ea [9];
    logic       ec [9];
    checks = 0;
    errors = 0;
    last_opnd = 8'h00;
    reset = 1'b0;
    tmif.req_valid  = 1'b0;
    tmif.req_op     = 4'd0;
    tmif.req_opnd   = 8'h00;
    tmif.rsp_ready  = 1'b0;
    tmif.bus_ready  = 1'b0;
    tmif.bus_valid  = 1'b0;
    tmif.bus_data   = 8'h00;
    tmif.bus_status = 2'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(tmif.req_ready), 32'd1);
    check("rst rsp_valid", 32'(tmif.rsp_valid), 32'd0);
    check("rst rsp_data", 32'(tmif.rsp_data), 32'd0);
    check("rst rsp_err", 32'(tmif.rsp_err), 32'd0);
    check("rst bus_op", 32'(tmif.bus_op), 32'h8);
    check("rst bus_opnd", 32'(tmif.bus_opnd), 32'd0);
    check("rst alarm", 32'(tmif.alarm), 32'd0);
    check("rst alarm_chg", 32'(tmif.alarm_chg), 32'd0);
    reset = 1'b1;

    //          op     opnd   rdy_at vld_dly bdata  lat iss data   err
    vecs[0]  = '{4'd2, 8'h50, 0,     NEVER,  8'h00, 3,  1,  8'h00, 1'b0};
    vecs[1]  = '{4'd0, 8'h00, 0,     NEVER,  8'h00, 3,  1,  8'h00, 1'b0};
    vecs[2]  = '{4'd1, 8'hA5, 5,     NEVER,  8'h00, 7,  1,  8'h00, 1'b0};
    vecs[3]  = '{4'd3, 8'h10, NEVER, NEVER,  8'h00, 17, 0,  8'h00, 1'b1};
    vecs[4]  = '{4'd4, 8'h00, 0,     4,      8'h3C, 7,  1,  8'h3C, 1'b0};
    vecs[5]  = '{4'd5, 8'h01, 0,     1,      8'h11, 4,  1,  8'h11, 1'b0};
    vecs[6]  = '{4'd6, 8'h7F, 0,     16,     8'hEE, 19, 1,  8'hEE, 1'b0};
    vecs[7]  = '{4'd7, 8'h00, 0,     NEVER,  8'h00, 19, 1,  8'h00, 1'b1};
    vecs[8]  = '{4'd7, 8'h02, 0,     17,     8'h99, 19, 1,  8'h00, 1'b1};
    vecs[9]  = '{4'd5, 8'h03, 0,     0,      8'h55, 19, 1,  8'h00, 1'b1};
    vecs[10] = '{4'd4, 8'hC3, 3,     2,      8'h5A, 7,  1,  8'h5A, 1'b0};
    vecs[11] = '{4'hA, 8'h33, 0,     NEVER,  8'h00, 1,  0,  8'h00, 1'b0};
    vecs[12] = '{4'hF, 8'h44, 0,     NEVER,  8'h00, 1,  0,  8'h00, 1'b0};
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // NOOP response held while host stalls; a request meanwhile must be ignored.
    @(negedge clk);
    tmif.req_valid = 1'b1;
    tmif.req_op    = 4'b1010;
    tmif.req_opnd  = 8'h44;
    @(negedge clk);
    check("hold first rsp_valid", 32'(tmif.rsp_valid), 32'd1);
    tmif.req_op   = 4'd2;
    tmif.req_opnd = 8'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d rsp_valid", k), 32'(tmif.rsp_valid), 32'd1);
      check($sformatf("hold%0d req_ready", k), 32'(tmif.req_ready), 32'd0);
      check($sformatf("hold%0d rsp_data", k), 32'(tmif.rsp_data), 32'd0);
      check($sformatf("hold%0d bus_op", k), 32'(tmif.bus_op), 32'h8);
    end
    tmif.req_valid = 1'b0;
    tmif.rsp_ready = 1'b1;
    @(negedge clk);
    tmif.rsp_ready = 1'b0;
    check("hold done rsp_valid", 32'(tmif.rsp_valid), 32'd0);
    check("hold done req_ready", 32'(tmif.req_ready), 32'd1);
    @(negedge clk);
    check("hold no stray bus_op", 32'(tmif.bus_op), 32'h8);
    check("hold still idle", 32'(tmif.req_ready), 32'd1);

    // Reset asserted while waiting for read data.
    tmif.bus_ready = 1'b1;
    tmif.req_valid = 1'b1;
    tmif.req_op    = 4'd4;
    tmif.req_opnd  = 8'h21;
    @(negedge clk);
    tmif.req_valid = 1'b0;
    @(negedge clk);
    check("abort issue bus_op", 32'(tmif.bus_op), 32'h4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort rsp_valid", 32'(tmif.rsp_valid), 32'd0);
    check("abort req_ready", 32'(tmif.req_ready), 32'd1);
    check("abort bus_op", 32'(tmif.bus_op), 32'h8);
    check("abort bus_opnd", 32'(tmif.bus_opnd), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    tmif.bus_valid = 1'b1;
    tmif.bus_data  = 8'h77;
    @(negedge clk);
    tmif.bus_valid = 1'b0;
    tmif.bus_data  = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("late vld%0d rsp_valid", k), 32'(tmif.rsp_valid), 32'd0);
    end

    // Alarm mirror: alarm lags bus_status one cycle, alarm_chg lags the change one more.
    st = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    ea = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tmif.bus_status = st[i];
      @(posedge clk);
      #1;
      check($sformatf("alarm%0d", i), 32'(tmif.alarm), 32'(ea[i]));
      check($sformatf("alarm_chg%0d", i), 32'(tmif.alarm_chg), 32'(ec[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmon_master.md
TMON_MASTER -- requirements
Module: tmon_master

Interface
REQ-001 Parameter DW, default 8, temperature/operand/data width.
REQ-002 Parameter TIMEOUT, default 16, max cycles waited in WAIT_RDY or WAIT_DATA; legal range 1..255.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  host command request.
REQ-006 req_ready  output  1  master can accept a command; high only in IDLE.
REQ-007 req_op  input  4  command code: 0 RESET, 1 SET_FRQ, 2 SET_HIGH_TEMP, 3 SET_LOW_TEMP, 4 OUT_MAX, 5 OUT_MIN, 6 OUT_ADDR, 7 OUT_AVG, 1xxx NOOP.
REQ-008 req_opnd  input  DW  command operand.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  host accepts response.
REQ-011 rsp_data  output  DW  read data; 0 for write, NOOP and timeout.
REQ-012 rsp_err  output  1  command timed out.
REQ-013 bus_op  output  4  tmon bus op code, registered; idle value 4'b1000 (NOOP).
REQ-014 bus_opnd  output  DW  tmon bus operand, registered.
REQ-015 bus_ready  input  1  slave ready.
REQ-016 bus_valid  input  1  slave data valid.
REQ-017 bus_data  input  DW  slave read data.
REQ-018 bus_status  input  2  slave status: 0 OK, 1 HIGH, 2 LOW.
REQ-019 alarm  output  2  registered copy of bus_status.
REQ-020 alarm_chg  output  1  one-cycle pulse when alarm changes value.

Function
REQ-021 FSM states: IDLE, WAIT_RDY, ISSUE, WAIT_DATA, RESP.
REQ-022 IDLE: on req_valid&&req_ready, latch req_op/req_opnd; op[3]=1 -> RESP with rsp_data=0, rsp_err=0; else -> WAIT_RDY.
REQ-023 WAIT_RDY: bus_op held NOOP; bus_ready=1 sampled -> ISSUE next cycle.
REQ-024 ISSUE: lasts exactly one cycle, bus_op=latched op and bus_opnd=latched opnd during it; ops 0-3 -> RESP, ops 4-7 -> WAIT_DATA.
REQ-025 bus_op SHALL return to NOOP the cycle after ISSUE; bus_opnd holds last value.
REQ-026 WAIT_DATA: bus_valid=1 sampled -> capture bus_data into rsp_data, rsp_err=0, -> RESP.
REQ-027 Timeout counter cleared on entry to WAIT_RDY and WAIT_DATA, increments each cycle in those states; reaching TIMEOUT without the awaited input -> RESP, rsp_err=1, rsp_data=0.
REQ-028 Write-op response latency with bus_ready=1 continuously: rsp_valid high 3 cycles after the accept edge.
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then -> IDLE; no new request accepted while in RESP.
REQ-030 bus_valid outside WAIT_DATA ignored; req_valid outside IDLE ignored (req_ready=0).
REQ-031 alarm updates every cycle from bus_status independent of FSM; alarm_chg=1 in the cycle after alarm != previous alarm; bus_status=3 registered as-is.
REQ-032 Simultaneous bus_valid and timeout in same cycle: bus_valid wins, rsp_err=0.

Reset
REQ-033 reset=0 at rising edge: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, bus_op=4'b1000, bus_opnd=0, alarm=0, alarm_chg=0, timeout counter=0.
REQ-034 Reset asserted mid-operation aborts the command with no response; bus_op NOOP the cycle after the reset edge.

Verification
REQ-035 SET_HIGH_TEMP opnd=8'h50, bus_ready=1 -> bus_op=2, bus_opnd=8'h50 for exactly one cycle; rsp_valid 3 cycles after accept, rsp_data=0, rsp_err=0.
REQ-036 OUT_MAX, bus_valid asserted 4 cycles after ISSUE with bus_data=8'h3C -> rsp_data=8'h3C, rsp_err=0.
REQ-037 OUT_AVG, TIMEOUT=16, bus_valid never asserted -> rsp_err=1, rsp_data=0 after 16 cycles in WAIT_DATA; bus_ready held 0 on a write op -> same timeout from WAIT_RDY, bus_op never leaves NOOP.
REQ-038 NOOP request (op=4'b1010) -> no bus activity, rsp_valid next cycle; rsp_ready held 0 for 5 cycles -> rsp_valid stays high, req_ready=0 throughout.
REQ-039 bus_status 0->1->1->2 -> alarm follows one cycle later, alarm_chg pulses twice.
REQ-040 reset=0 during WAIT_DATA -> next cycle IDLE, rsp_valid=0, bus_op=4'b1000; late bus_valid afterwards produces no response.
